// File: rtl/async_fifo_1clk.sv
// Single-clock show-ahead FIFO with full/afull/empty/aempty flags.
// Optional sticky overflow/underflow outputs when ASYNC_FIFO_ERR_FLAG_EN is defined.
module async_fifo_1clk #(
    parameter int W  = 8,
    parameter int DP = 4
) (
    input  logic         wb_clk_i,
    input  logic         wb_rst_i,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    output logic         full,
    output logic         afull,
    input  logic         rd_en,
    output logic [W-1:0] rd_data,
    output logic         empty,
`ifdef ASYNC_FIFO_ERR_FLAG_EN
    output logic         ovf_err,
    output logic         udf_err,
`endif
    output logic         aempty
);

    localparam int AW    = $clog2(DP);
    localparam int PTR_W = AW + 1;
    localparam logic [PTR_W-1:0] DEPTH_C = PTR_W'(DP);
    localparam logic [PTR_W-1:0] AFULL_C = PTR_W'(DP - 1);
    localparam logic [PTR_W-1:0] ONE_C   = PTR_W'(1);
    localparam logic [PTR_W-1:0] ZERO_C  = PTR_W'(0);

    logic [W-1:0]     mem_q [DP];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] rd_ptr_d;
    logic [PTR_W-1:0] count_s;
    logic             wr_ok_s;
    logic             rd_ok_s;

    // Occupancy and flags, derived only from the registered pointers.
    always_comb begin
        count_s = wr_ptr_q - rd_ptr_q;
        full    = (count_s == DEPTH_C);
        afull   = (count_s >= AFULL_C);
        empty   = (count_s == ZERO_C);
        aempty  = (count_s <= ONE_C);
        rd_data = mem_q[rd_ptr_q[AW-1:0]];
    end

    // Accept decisions use pre-edge flags, so full+write and empty+read are dropped.
    always_comb begin
        wr_ok_s  = wr_en & ~full;
        rd_ok_s  = rd_en & ~empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_ok_s) begin
            wr_ptr_d = wr_ptr_q + ONE_C;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (rd_ok_s) begin
            rd_ptr_d = rd_ptr_q + ONE_C;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
    end

    // Pointer registers; the extra MSB is the wrap bit.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wr_ptr_q <= ZERO_C;
            rd_ptr_q <= ZERO_C;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage array is intentionally not reset.
    always_ff @(posedge wb_clk_i) begin
        if (wr_ok_s) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
        end
    end

`ifdef ASYNC_FIFO_ERR_FLAG_EN
    logic ovf_q;
    logic ovf_d;
    logic udf_q;
    logic udf_d;

    // Sticky error capture; only reset clears them.
    always_comb begin
        ovf_d = ovf_q | (wr_en & full);
        udf_d = udf_q | (rd_en & empty);
    end

    // Error flag registers.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            udf_q <= udf_d;
        end
    end

    assign ovf_err = ovf_q;
    assign udf_err = udf_q;
`endif

endmodule

// File: tb/tb_async_fifo_1clk.sv
// Self-checking bench for async_fifo_1clk (W=8, DP=4) against a queue-based model.
module tb_async_fifo_1clk;

    localparam int W  = 8;
    localparam int DP = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         wr_en = 1'b0;
    logic         rd_en = 1'b0;
    logic [W-1:0] wr_data = '0;
    logic         full, afull, empty, aempty;
    logic [W-1:0] rd_data;
`ifdef ASYNC_FIFO_ERR_FLAG_EN
    logic         ovf_err, udf_err;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    logic [W-1:0] q[$];
    bit m_ovf = 1'b0;
    bit m_udf = 1'b0;

    async_fifo_1clk #(.W(W), .DP(DP)) dut (
        .wb_clk_i(clk),
        .wb_rst_i(rst),
        .wr_en(wr_en),
        .wr_data(wr_data),
        .full(full),
        .afull(afull),
        .rd_en(rd_en),
        .rd_data(rd_data),
        .empty(empty),
`ifdef ASYNC_FIFO_ERR_FLAG_EN
        .ovf_err(ovf_err),
        .udf_err(udf_err),
`endif
        .aempty(aempty)
    );

    always #5 clk = ~clk;

    // Expected {full, afull, empty, aempty} from model occupancy.
    function automatic logic [3:0] exp_flags();
        int n;
        n = q.size();
        return {n == DP, n >= DP - 1, n == 0, n <= 1};
    endfunction

    // One clock edge; the model applies the same accept rules using pre-edge occupancy.
    task automatic tick();
        bit w_ok, r_ok;
        w_ok = wr_en && (q.size() < DP);
        r_ok = rd_en && (q.size() > 0);
        if (wr_en && q.size() == DP) m_ovf = 1'b1;
        if (rd_en && q.size() == 0) m_udf = 1'b1;
        @(posedge clk);
        #1;
        if (r_ok) void'(q.pop_front());
        if (w_ok) q.push_back(wr_data);
    endtask

    task automatic reset_model();
        q.delete();
        m_ovf = 1'b0;
        m_udf = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        n_tests++;
        if ({full, afull, empty, aempty} !== 4'b0011) begin
            n_fail++;
            $display("FAIL reset_flags: got %b want %b", {full, afull, empty, aempty}, 4'b0011);
        end
`ifdef ASYNC_FIFO_ERR_FLAG_EN
        n_tests++;
        if ({ovf_err, udf_err} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_err: got %b want 00", {ovf_err, udf_err});
        end
`endif
        #1 rst = 1'b0;
        reset_model();
    endtask

    task automatic test_fill();
        logic [W-1:0] vals [5];
        vals = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        for (int i = 0; i < 5; i++) begin
            wr_en = 1'b1;
            wr_data = vals[i];
            tick();
            n_tests++;
            if ({full, afull, empty, aempty} !== exp_flags()) begin
                n_fail++;
                $display("FAIL fill_flags[%0d]: got %b want %b", i, {full, afull, empty, aempty}, exp_flags());
            end
            n_tests++;
            if (rd_data !== 8'h11) begin
                n_fail++;
                $display("FAIL fill_head[%0d]: got %h want 11", i, rd_data);
            end
        end
        wr_en = 1'b0;
`ifdef ASYNC_FIFO_ERR_FLAG_EN
        n_tests++;
        if (ovf_err !== m_ovf) begin
            n_fail++;
            $display("FAIL ovf_err: got %b want %b", ovf_err, m_ovf);
        end
`endif
    endtask

    task automatic test_drain();
        logic [W-1:0] exp_v;
        for (int i = 0; i < 5; i++) begin
            exp_v = (q.size() > 0) ? q[0] : 8'h00;
            if (q.size() > 0) begin
                n_tests++;
                if (rd_data !== exp_v) begin
                    n_fail++;
                    $display("FAIL drain_data[%0d]: got %h want %h", i, rd_data, exp_v);
                end
            end
            rd_en = 1'b1;
            tick();
            n_tests++;
            if ({full, afull, empty, aempty} !== exp_flags()) begin
                n_fail++;
                $display("FAIL drain_flags[%0d]: got %b want %b", i, {full, afull, empty, aempty}, exp_flags());
            end
        end
        rd_en = 1'b0;
`ifdef ASYNC_FIFO_ERR_FLAG_EN
        n_tests++;
        if (udf_err !== m_udf) begin
            n_fail++;
            $display("FAIL udf_err: got %b want %b", udf_err, m_udf);
        end
`endif
    endtask

    task automatic test_simul();
        int targets [3];
        targets = '{2, DP, 0};
        for (int t = 0; t < 3; t++) begin
            while (q.size() < targets[t]) begin
                wr_en = 1'b1; rd_en = 1'b0; wr_data = 8'($urandom);
                tick();
            end
            while (q.size() > targets[t]) begin
                wr_en = 1'b0; rd_en = 1'b1;
                tick();
            end
            wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'hC0 + 8'(t);
            tick();
            wr_en = 1'b0; rd_en = 1'b0;
            n_tests++;
            if ({full, afull, empty, aempty} !== exp_flags()) begin
                n_fail++;
                $display("FAIL simul_flags[%0d]: got %b want %b", t, {full, afull, empty, aempty}, exp_flags());
            end
            n_tests++;
            if (q.size() > 0 && rd_data !== q[0]) begin
                n_fail++;
                $display("FAIL simul_head[%0d]: got %h want %h", t, rd_data, q[0]);
            end
        end
        while (q.size() > 0) begin
            rd_en = 1'b1;
            tick();
        end
        rd_en = 1'b0;
    endtask

    task automatic test_wrap();
        int next_wr = 0;
        int next_rd = 0;
        int iter = 0;
        while (next_rd < 20 && iter < 300) begin
            iter++;
            wr_en = 1'b0; rd_en = 1'b0;
            if (next_wr < 20 && (q.size() <= 1 || (q.size() < 3 && $urandom_range(1) == 0))) begin
                wr_en = 1'b1;
                wr_data = 8'(next_wr);
                next_wr++;
            end else if (q.size() > 0) begin
                n_tests++;
                if (rd_data !== 8'(next_rd)) begin
                    n_fail++;
                    $display("FAIL wrap_order[%0d]: got %h want %h", next_rd, rd_data, 8'(next_rd));
                end
                rd_en = 1'b1;
                next_rd++;
            end
            tick();
            n_tests++;
            if ({full, afull, empty, aempty} !== exp_flags()) begin
                n_fail++;
                $display("FAIL wrap_flags[%0d]: got %b want %b", iter, {full, afull, empty, aempty}, exp_flags());
            end
        end
        wr_en = 1'b0; rd_en = 1'b0;
        n_tests++;
        if (next_rd != 20) begin
            n_fail++;
            $display("FAIL wrap_timeout: got %0d reads want 20", next_rd);
        end
    endtask

    task automatic test_show_ahead();
        wr_en = 1'b1; wr_data = 8'hA5;
        tick();
        wr_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if (rd_data !== 8'hA5 || empty !== 1'b0) begin
                n_fail++;
                $display("FAIL show_ahead[%0d]: got %h/%b want a5/0", i, rd_data, empty);
            end
            tick();
        end
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        n_tests++;
        if (empty !== 1'b1) begin
            n_fail++;
            $display("FAIL show_ahead_pop: got empty=%b want 1", empty);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            wr_en = 1'($urandom);
            rd_en = 1'($urandom);
            wr_data = 8'($urandom);
            tick();
            n_tests++;
            if ({full, afull, empty, aempty} !== exp_flags()) begin
                n_fail++;
                $display("FAIL rand_flags[%0d]: got %b want %b", i, {full, afull, empty, aempty}, exp_flags());
            end
            if (q.size() > 0) begin
                n_tests++;
                if (rd_data !== q[0]) begin
                    n_fail++;
                    $display("FAIL rand_head[%0d]: got %h want %h", i, rd_data, q[0]);
                end
            end
        end
        wr_en = 1'b0; rd_en = 1'b0;
`ifdef ASYNC_FIFO_ERR_FLAG_EN
        n_tests++;
        if ({ovf_err, udf_err} !== {m_ovf, m_udf}) begin
            n_fail++;
            $display("FAIL rand_err: got %b want %b", {ovf_err, udf_err}, {m_ovf, m_udf});
        end
`endif
    endtask

    task automatic test_reset_mid();
        rst = 1'b1;
        #1;
        rst = 1'b0;
        reset_model();
        for (int i = 0; i < 3; i++) begin
            wr_en = 1'b1; wr_data = 8'h70 + 8'(i);
            tick();
        end
        wr_en = 1'b0;
        n_tests++;
        if (empty !== 1'b0) begin
            n_fail++;
            $display("FAIL premid_empty: got %b want 0", empty);
        end
        #2 rst = 1'b1;
        #1;
        n_tests++;
        if ({full, afull, empty, aempty} !== 4'b0011) begin
            n_fail++;
            $display("FAIL mid_reset_flags: got %b want 0011", {full, afull, empty, aempty});
        end
`ifdef ASYNC_FIFO_ERR_FLAG_EN
        n_tests++;
        if ({ovf_err, udf_err} !== 2'b00) begin
            n_fail++;
            $display("FAIL mid_reset_err: got %b want 00", {ovf_err, udf_err});
        end
`endif
        #1 rst = 1'b0;
        reset_model();
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_simul();
        test_wrap();
        test_show_ahead();
        test_random();
        test_reset_mid();
        test_fill();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/async_fifo_1clk.md
Name: async_fifo_1clk

Overview:
- Single-clock, show-ahead (first-word-fall-through) FIFO with the same port contract as the dual-clock FIFO used in the WISHBONE-to-SDRAM bridge.
- Buffers W-bit words (command, write-data+mask or read-data+EOP) with full/almost-full and empty/almost-empty flags.
- Both the write side and the read side run on one clock and one reset.

Parameters:
- W, 8, data word width in bits (≥1).
- DP, 4, depth in words; power of two, ≥2.

Ports:
- wb_clk_i  input  1  clock; all state updates on its rising edge.
- wb_rst_i  input  1  asynchronous reset, active-high.
- wr_en  input  1  write request; the word is stored at the rising edge if the FIFO is not full.
- wr_data  input  W  write word.
- full  output  1  FIFO holds DP words.
- afull  output  1  FIFO holds ≥ DP-1 words.
- rd_en  input  1  pop request; the head is removed at the rising edge if the FIFO is not empty.
- rd_data  output  W  head word (show-ahead), valid while empty=0.
- empty  output  1  FIFO holds 0 words.
- aempty  output  1  FIFO holds ≤ 1 word.

Behaviour:
- Storage: DP×W register array, not reset. Write and read pointers are log2(DP)+1 bits, the MSB being the wrap bit.
- Occupancy: count = wr_ptr - rd_ptr (modulo 2·DP). Flags are combinational from the registered pointers:
  - full = (count==DP)
  - afull = (count≥DP-1)
  - empty = (count==0)
  - aempty = (count≤1)
- Reset (asynchronous, wb_rst_i=1):
  - wr_ptr=0, rd_ptr=0.
  - empty=1, aempty=1, full=0, afull=0.
  - rd_data undefined until the first write.
  - Reset mid-operation discards all contents immediately; flags return to reset values without waiting for a clock edge.
- Write: wr_en=1 and full=0 → mem[wr_ptr[low]] ← wr_data, wr_ptr+1. wr_en=1 with full=1 is ignored: no pointer or memory change.
- Read: rd_en=1 and empty=0 → rd_ptr+1. rd_en=1 with empty=1 is ignored.
- rd_data = mem[rd_ptr[low]], combinational (zero-latency head). It updates in the cycle after a pop, and in the cycle after the first write into an empty FIFO.
- Latency: a word written at edge N is visible on rd_data and clears empty right after edge N. A pop at edge N presents the next word right after edge N.
- Simultaneous write and read:
  - Neither full nor empty: both happen; count unchanged; flags unchanged.
  - When full: the read happens, the write is dropped (the flag is evaluated before the edge); count goes DP→DP-1.
  - When empty: the write happens, the read is dropped; count goes 0→1.
- Wrap-around: pointer low bits wrap modulo DP. The wrap bit distinguishes full from empty; unbounded operation must keep working.
- No combinational path from wr_en/rd_en to any flag or to rd_data.

Optional Feature:
- Macro ASYNC_FIFO_ERR_FLAG_EN.
- When defined, add outputs ovf_err (1) and udf_err (1):
  - Both reset to 0 by wb_rst_i.
  - ovf_err sets, and stays sticky, at the edge where wr_en=1 and full=1.
  - udf_err sets, and stays sticky, at the edge where rd_en=1 and empty=1.
  - Both clear only on reset.
- When undefined, neither port exists. Dropped writes and ignored reads remain silently protected exactly as in Behaviour.

Test Plan (W=8, DP=4):
- Reset → empty=1, aempty=1, full=0, afull=0. Then assert wb_rst_i mid-stream with 3 words stored → empty=1 immediately, before the next clock.
- Write 0x11,0x22,0x33,0x44 on consecutive cycles, rd_en=0:
  - After write 1: empty=0, aempty=1, rd_data=0x11.
  - After write 2: aempty=0.
  - After write 3: afull=1.
  - After write 4: full=1.
  - Fifth write 0x55 dropped; contents and count unchanged (ovf_err=1 with macro).
- From full, pop 4 times → rd_data sequence 0x11,0x22,0x33,0x44. After pop 1: full=0. After pop 4: empty=1. A further rd_en changes nothing (udf_err=1 with macro).
- Simultaneous wr_en/rd_en:
  - At count 2: count stays 2, rd_data advances.
  - At full: count becomes 3, the write is lost.
  - At empty: count becomes 1, rd_data shows the written word.
- Wrap: stream 20 words 0x00–0x13 with interleaved single writes and pops, occupancy kept 1–3 → read order exactly 0x00–0x13, no flag glitches at each pointer wrap.
- Show-ahead: write 0xA5 into an empty FIFO → rd_data=0xA5 the cycle after the write edge with rd_en=0; it stays 0xA5 until popped.
